mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
Control unit that sequences the 32-bit shift-add multiplier datapath for MULTU-class operations. It accepts a start request with two operands, clears the multiplier, runs the MUL step code for ITER cycles, issues OUT, and captures the 64-bit product into HI/LO architectural registers. It sits between the decode/execute stage and the multiplier, and provides busy/done status and stall-on-read for MFHI/MFLO.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH.
ITER, 32, number of MUL step cycles; equals WIDTH.
SIG_MUL, 6'b011001, multiplier step code driven on mul_signal.
SIG_OUT, 6'b111111, multiplier output/hold code.
SIG_NOP, 6'b000000, idle code.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request a new multiply; sampled each rising edge.
op_a  in  WIDTH  multiplicand; sampled when start is accepted.
op_b  in  WIDTH  multiplier; sampled when start is accepted.
rd_en  in  1  MFHI/MFLO read request.
rd_sel  in  1  0 = LO, 1 = HI.
mul_data_a  out  WIDTH  latched multiplicand to the datapath.
mul_data_b  out  WIDTH  latched multiplier to the datapath.
mul_signal  out  6  step code to the datapath.
mul_clr  out  1  synchronous clear of the datapath product accumulator.
mul_product  in  2*WIDTH  product from the datapath.
busy  out  1  multiply in progress.
done  out  1  one-cycle pulse; HI/LO updated.
start_ignored  out  1  one-cycle pulse when start is rejected.
hi  out  WIDTH  upper product half.
lo  out  WIDTH  lower product half.
rd_data  out  WIDTH  combinational: rd_sel ? hi : lo.
stall  out  1  combinational: rd_en & busy.

Behaviour:
- Reset is synchronous, active-high, on clk only. When reset is high at an edge:
  - State goes to IDLE.
  - hi, lo, mul_data_a, mul_data_b and the counter go to 0.
  - busy, done and start_ignored go to 0.
  - mul_signal goes to SIG_NOP.
  - mul_clr is 1 during any cycle in which reset is high.
  - Reset overrides start in the same cycle.
- States: IDLE, CLEAR, RUN, OUT, DONE. mul_signal and mul_clr are decoded from the state (Moore outputs).
- IDLE: mul_signal = NOP. If start = 1: latch op_a/op_b into mul_data_a/b, zero the counter, go to CLEAR.
- CLEAR (1 cycle): mul_clr = 1, mul_signal = NOP, busy = 1. Go to RUN.
- RUN: mul_signal = SIG_MUL, busy = 1. The counter increments each cycle. When the counter equals ITER-1, go to OUT. RUN lasts exactly ITER cycles.
- OUT (1 cycle): mul_signal = SIG_OUT, busy = 1. At the edge, {hi, lo} <= mul_product with no truncation. Go to DONE.
- DONE (1 cycle): done = 1, busy = 0, mul_signal = NOP.
  - If start = 1: accept it exactly as in IDLE (back-to-back) and go to CLEAR.
  - Otherwise go to IDLE.
- Latency: start sampled at edge E0; done is high in the cycle after edge E0+ITER+2, which is 35 cycles for ITER = 32. hi/lo are valid in that same cycle.
- start while busy (CLEAR/RUN/OUT): request is ignored, start_ignored pulses for 1 cycle, and op_a/op_b are not latched.
- mul_data_a/b hold their values from start acceptance until the next accept; they are unchanged in IDLE.
- hi/lo change only in OUT; they hold their old values throughout a run and after reset-aborted runs stay 0.
- Reads:
  - During a run, rd_data returns the old hi/lo value and stall = rd_en.
  - In DONE and IDLE, stall = 0 and rd_data returns the new value.
- Reset mid-run: operation abandoned, no done pulse, state IDLE on the next cycle.

Test Plan:
1. Basic: reset 2 cycles; start with op_a = 3, op_b = 5 → busy = 1 for 34 cycles, mul_signal = SIG_MUL for exactly 32 cycles, done pulse 35 cycles after start; hi = 0, lo = 15 (datapath model returns the product).
2. Maximum: op_a = op_b = 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001; op_a = 0 → hi = lo = 0.
3. Overrun: start again at cycle 10 of RUN with op_a = 7 → start_ignored pulses once, mul_data_a keeps its value, and the final result belongs to the first operation only.
4. Back-to-back: start held high continuously with operands 2×3, then 4×5 → done pulses 35 cycles apart in steady state; lo = 6, then lo = 20; there is no IDLE cycle between the runs.
5. Reset mid-run: reset asserted at RUN cycle 16 → next cycle IDLE, busy = 0, mul_clr = 1 during reset, hi = lo = 0, no done pulse; a subsequent 6×7 run yields lo = 42.
6. Read stall: rd_en = 1, rd_sel = 1 during a run → stall = 1 and rd_data = old hi; in the DONE cycle stall = 0 and rd_data = new hi.

Source files
------------

// File: rtl/mul_sequencer.sv
// Sequences the shift-add multiplier (clear, ITER step cycles, output) and captures the product into HI/LO.
// Start-to-done is ITER+3 cycles; start while busy is dropped and flagged, reads of HI/LO stall while busy.
module mul_sequencer #(
  parameter int         WIDTH   = 32,
  parameter int         ITER    = 32,
  parameter logic [5:0] SIG_MUL = 6'b011001,
  parameter logic [5:0] SIG_OUT = 6'b111111,
  parameter logic [5:0] SIG_NOP = 6'b000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               rd_en,
  input  logic               rd_sel,
  output logic [WIDTH-1:0]   mul_data_a,
  output logic [WIDTH-1:0]   mul_data_b,
  output logic [5:0]         mul_signal,
  output logic               mul_clr,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic               busy,
  output logic               done,
  output logic               start_ignored,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic [WIDTH-1:0]   rd_data,
  output logic               stall
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_OUT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [5:0] sig;
    logic       clr;
    logic       busy;
    logic       done;
  } outs_t;

  state_t        state;
  outs_t         outs;
  logic [CW-1:0] cnt;

  // Outputs are registered together with the state they belong to, so they stay pure Moore.
  function automatic outs_t decode(input state_t s);
    outs_t o;
    o.sig  = SIG_NOP;
    o.clr  = 1'b0;
    o.busy = 1'b0;
    o.done = 1'b0;
    case (s)
      S_CLEAR: begin
        o.clr  = 1'b1;
        o.busy = 1'b1;
      end
      S_RUN: begin
        o.sig  = SIG_MUL;
        o.busy = 1'b1;
      end
      S_OUT: begin
        o.sig  = SIG_OUT;
        o.busy = 1'b1;
      end
      S_DONE:  o.done = 1'b1;
      default: o = o;
    endcase
    return o;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      outs          <= decode(S_IDLE);
      cnt           <= '0;
      mul_data_a    <= '0;
      mul_data_b    <= '0;
      hi            <= '0;
      lo            <= '0;
      start_ignored <= 1'b0;
    end else begin
      start_ignored <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mul_data_a <= op_a;
            mul_data_b <= op_b;
            cnt        <= '0;
            state      <= S_CLEAR;
            outs       <= decode(S_CLEAR);
          end else begin
            state <= S_IDLE;
            outs  <= decode(S_IDLE);
          end
        end
        S_CLEAR: begin
          start_ignored <= start;
          state         <= S_RUN;
          outs          <= decode(S_RUN);
        end
        S_RUN: begin
          start_ignored <= start;
          cnt           <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_OUT;
            outs  <= decode(S_OUT);
          end
        end
        S_OUT: begin
          start_ignored <= start;
          {hi, lo}      <= mul_product;
          state         <= S_DONE;
          outs          <= decode(S_DONE);
        end
        default: begin
          state <= S_IDLE;
          outs  <= decode(S_IDLE);
        end
      endcase
    end
  end

  // Reset must clear the datapath in the very cycle it is asserted, hence the combinational term.
  assign mul_clr    = outs.clr | reset;
  assign mul_signal = outs.sig;
  assign busy       = outs.busy;
  assign done       = outs.done;

  assign rd_data = rd_sel ? hi : lo;
  assign stall   = rd_en & busy;

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a behavioural shift-add datapath.
module tb_mul_sequencer;

  localparam logic [5:0] SIG_MUL = 6'b011001;
  localparam logic [5:0] SIG_OUT = 6'b111111;
  localparam logic [5:0] SIG_NOP = 6'b000000;

  logic        clk = 1'b0;
  logic        reset, start, rd_en, rd_sel;
  logic [31:0] op_a, op_b;
  logic [31:0] mul_data_a, mul_data_b, hi, lo, rd_data;
  logic [5:0]  mul_signal;
  logic        mul_clr, busy, done, start_ignored, stall;
  logic [63:0] mul_product;
  logic [5:0]  idx;

  int errors = 0;
  int checks = 0;

  mul_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .rd_en(rd_en), .rd_sel(rd_sel), .mul_data_a(mul_data_a), .mul_data_b(mul_data_b),
    .mul_signal(mul_signal), .mul_clr(mul_clr), .mul_product(mul_product),
    .busy(busy), .done(done), .start_ignored(start_ignored), .hi(hi), .lo(lo),
    .rd_data(rd_data), .stall(stall)
  );

  always #5 clk = ~clk;

  // Datapath model: one shift-add step per SIG_MUL cycle.
  always @(posedge clk) begin
    if (mul_clr) begin
      mul_product <= 64'd0;
      idx         <= 6'd0;
    end else if (mul_signal == SIG_MUL) begin
      if (mul_data_b[idx[4:0]]) mul_product <= mul_product + ({32'd0, mul_data_a} << idx);
      idx <= idx + 6'd1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a multiply and profiles it until done; first observed cycle (CLEAR) is cycle 1.
  task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc = 0, busy_cnt = 0, mul_cnt = 0, clr_cnt = 0;
    bit seen = 0;
    op_a = a; op_b = b; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      cyc++;
      if (busy) busy_cnt++;
      if (mul_signal == SIG_MUL) mul_cnt++;
      if (mul_clr) clr_cnt++;
      if (done) seen = 1; else tick();
    end
    checks++; if (!seen || cyc !== 35) begin errors++; $display("FAIL %s latency: got %0d cycles, want 35", name, cyc); end
    checks++; if (busy_cnt !== 34) begin errors++; $display("FAIL %s busy cycles: got %0d, want 34", name, busy_cnt); end
    checks++; if (mul_cnt !== 32) begin errors++; $display("FAIL %s mul cycles: got %0d, want 32", name, mul_cnt); end
    checks++; if (clr_cnt !== 1) begin errors++; $display("FAIL %s clr cycles: got %0d, want 1", name, clr_cnt); end
    checks++; if (hi !== exp_hi || lo !== exp_lo) begin
      errors++; $display("FAIL %s product: got hi=%h lo=%h, want hi=%h lo=%h", name, hi, lo, exp_hi, exp_lo);
    end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || mul_signal !== SIG_NOP) begin
      errors++; $display("FAIL %s idle after done: got done=%b busy=%b sig=%h, want 0 0 00", name, done, busy, mul_signal);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (mul_clr !== 1'b1) begin errors++; $display("FAIL reset mul_clr: got %b want 1", mul_clr); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || start_ignored !== 1'b0 || mul_signal !== SIG_NOP) begin
      errors++; $display("FAIL reset status: got busy=%b done=%b ign=%b sig=%h, want 0 0 0 00", busy, done, start_ignored, mul_signal);
    end
    checks++; if (hi !== 32'd0 || lo !== 32'd0 || mul_data_a !== 32'd0 || mul_data_b !== 32'd0) begin
      errors++; $display("FAIL reset regs: got hi=%h lo=%h a=%h b=%h, want 0", hi, lo, mul_data_a, mul_data_b);
    end
    reset = 1'b0;
    tick();
    checks++; if (mul_clr !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL post-reset: got clr=%b busy=%b want 0 0", mul_clr, busy); end
  endtask

  task automatic test_basic();
    run_mul("basic_3x5", 32'd3, 32'd5, 32'd0, 32'd15);
    checks++; if (mul_data_a !== 32'd3 || mul_data_b !== 32'd5) begin
      errors++; $display("FAIL basic operand hold: got a=%0d b=%0d want 3 5", mul_data_a, mul_data_b);
    end
  endtask

  task automatic test_max();
    run_mul("zero", 32'd0, 32'h1234, 32'd0, 32'd0);
    run_mul("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
  endtask

  task automatic test_overrun();
    bit seen = 0;
    int pulses = 0;
    op_a = 32'd9; op_b = 32'd11; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    checks++; if (mul_signal !== SIG_MUL || busy !== 1'b1) begin
      errors++; $display("FAIL overrun in run: got sig=%h busy=%b want 19 1", mul_signal, busy);
    end
    op_a = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (start_ignored !== 1'b1) begin errors++; $display("FAIL overrun pulse: got %b want 1", start_ignored); end
    checks++; if (mul_data_a !== 32'd9) begin errors++; $display("FAIL overrun mul_data_a: got %0d want 9", mul_data_a); end
    for (int i = 0; i < 60 && !seen; i++) begin
      tick();
      if (start_ignored) pulses++;
      if (done) seen = 1;
    end
    checks++; if (!seen || pulses !== 0) begin errors++; $display("FAIL overrun finish: got done=%b extra pulses=%0d want 1 0", seen, pulses); end
    checks++; if (hi !== 32'd0 || lo !== 32'd99 || mul_data_a !== 32'd9) begin
      errors++; $display("FAIL overrun result: got hi=%0d lo=%0d a=%0d want 0 99 9", hi, lo, mul_data_a);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bit seen = 0;
    int gap = 0;
    op_a = 32'd2; op_b = 32'd3; start = 1'b1;
    tick();
    op_a = 32'd4; op_b = 32'd5;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done) seen = 1; else tick();
    end
    checks++; if (!seen || lo !== 32'd6) begin errors++; $display("FAIL b2b first: got done=%b lo=%0d want 1 6", seen, lo); end
    tick();
    checks++; if (busy !== 1'b1 || mul_clr !== 1'b1 || mul_data_a !== 32'd4) begin
      errors++; $display("FAIL b2b no idle: got busy=%b clr=%b a=%0d want 1 1 4", busy, mul_clr, mul_data_a);
    end
    gap = 1;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done) seen = 1; else begin tick(); gap++; end
    end
    start = 1'b0;
    checks++; if (!seen || gap !== 35) begin errors++; $display("FAIL b2b spacing: got %0d want 35", gap); end
    checks++; if (hi !== 32'd0 || lo !== 32'd20) begin errors++; $display("FAIL b2b second: got hi=%0d lo=%0d want 0 20", hi, lo); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b idle: got busy=%b done=%b want 0 0", busy, done); end
  endtask

  task automatic test_read_stall();
    bit seen = 0;
    rd_en = 1'b1; rd_sel = 1'b1;
    op_a = 32'h10000; op_b = 32'h10000; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (stall !== 1'b1 || rd_data !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL read during run: got stall=%b data=%h want 1 fffffffe", stall, rd_data);
    end
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done) seen = 1; else tick();
    end
    checks++; if (!seen || stall !== 1'b0 || rd_data !== 32'd1) begin
      errors++; $display("FAIL read at done: got stall=%b data=%h want 0 00000001", stall, rd_data);
    end
    rd_sel = 1'b0;
    #1;
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL read lo at done: got %h want 0", rd_data); end
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL read idle stall: got %b want 0", stall); end
    rd_en = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int dones = 0;
    op_a = 32'd8; op_b = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 17; i++) tick();
    checks++; if (mul_signal !== SIG_MUL) begin errors++; $display("FAIL rst-mid in run: got sig=%h want 19", mul_signal); end
    reset = 1'b1;
    #1;
    checks++; if (mul_clr !== 1'b1) begin errors++; $display("FAIL rst-mid clr: got %b want 1", mul_clr); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || mul_signal !== SIG_NOP || mul_clr !== 1'b1) begin
      errors++; $display("FAIL rst-mid state: got busy=%b done=%b sig=%h clr=%b want 0 0 00 1", busy, done, mul_signal, mul_clr);
    end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rst-mid hilo: got %h %h want 0 0", hi, lo); end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) dones++;
    end
    checks++; if (dones !== 0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL rst-mid abandon: got activity=%0d hi=%h lo=%h want 0 0 0", dones, hi, lo);
    end
    run_mul("after_reset_6x7", 32'd6, 32'd7, 32'd0, 32'd42);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rd_en = 1'b0; rd_sel = 1'b0;
    op_a = 32'd0; op_b = 32'd0;
    test_reset();
    test_basic();
    test_overrun();
    test_back_to_back();
    test_max();
    test_read_stall();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
